alu_seq_ctrl: RTL

Command sequencer for the shared 8-bit ALU core. It accepts one `alu_cmd_t` at a time and consumes `num_words` operands from a `uint_vld_t` stream. For ADD/SUB/MUL/DIV it folds them left-to-right through the external ALU over a req/ack handshake. MEAN is computed locally with a wide accumulator and a serial divider. It sits between the command/data front end and the ALU core, and returns one `uint_vld_t` result per command.

---
 rtl/alu_seq_ctrl.sv | 235 +++++++++++++++++++++++
 1 files changed

// File: rtl/alu_seq_ctrl.sv
// Command sequencer for the shared 8-bit ALU: folds operand streams through the
// external ALU (ADD/SUB/MUL/DIV) or computes MEAN locally with a serial divider.
package alu_pkg;
  localparam int INT_WIDTH      = 8;
  localparam int NUM_WORD_WIDTH = 10;
  localparam int SUM_WIDTH      = 18;

  typedef logic [INT_WIDTH-1:0] uint_t;

  typedef struct packed {
    logic  vld;
    uint_t data;
  } uint_vld_t;

  typedef enum logic [2:0] {
    ALU_ADD  = 3'd0,
    ALU_SUB  = 3'd1,
    ALU_MUL  = 3'd2,
    ALU_DIV  = 3'd3,
    ALU_MEAN = 3'd4
  } ALU_OP_E;

  // op is a raw field so that undefined opcodes can be presented and rejected
  typedef struct packed {
    logic                      vld;
    logic [2:0]                op;
    logic [NUM_WORD_WIDTH-1:0] num_words;
  } alu_cmd_t;

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_LOAD     = 3'd1,
    S_FETCH    = 3'd2,
    S_ALU_WAIT = 3'd3,
    S_MDIV     = 3'd4,
    S_DONE     = 3'd5
  } seq_state_e;
endpackage

module alu_seq_ctrl
  import alu_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  alu_cmd_t   cmd_i,
  output logic       cmd_rdy_o,
  input  uint_vld_t  data_i,
  output logic       data_rdy_o,
  output logic       alu_req_o,
  output ALU_OP_E    alu_op_o,
  output uint_t      alu_a_o,
  output uint_t      alu_b_o,
  input  logic       alu_ack_i,
  input  uint_t      alu_res_i,
  output uint_vld_t  res_o,
  output logic       err_o,
  output logic       busy_o,
  output seq_state_e state_o
);

  localparam int                      DIV_ITERS = SUM_WIDTH;
  localparam logic [4:0]              DIV_LAST  = 5'(DIV_ITERS - 1);
  localparam logic [NUM_WORD_WIDTH-1:0] ONE_WORD = NUM_WORD_WIDTH'(1);

  seq_state_e state, state_nxt;

  logic [2:0]                op_q;
  logic [NUM_WORD_WIDTH-1:0] n_q;
  logic [NUM_WORD_WIDTH-1:0] cnt_q;
  uint_t                     acc_q;
  uint_t                     b_q;
  logic                      err_q;
  logic [SUM_WIDTH-1:0]      sum_q;
  logic [SUM_WIDTH-1:0]      div_q;
  logic [NUM_WORD_WIDTH-1:0] rem_q;
  logic [4:0]                it_q;

  logic                      cmd_fire, data_fire, ack_fire;
  logic                      cmd_bad, is_mean, fetch_last, alu_last;
  logic [SUM_WIDTH-1:0]      sum_nxt;
  logic [NUM_WORD_WIDTH:0]   rem_sh, rem_diff;
  logic                      rem_ge;
  logic [NUM_WORD_WIDTH-1:0] rem_step;
  logic [SUM_WIDTH-1:0]      q_step;

  // Handshakes: a transfer happens in a cycle where the producer's valid and the
  // consumer's ready are both high; ready never depends on valid, and reset
  // forces every ready/request low in the same cycle.
  assign cmd_fire  = cmd_i.vld && (state == S_IDLE) && !rst;
  assign data_fire = data_i.vld && ((state == S_LOAD) || (state == S_FETCH)) && !rst;
  assign ack_fire  = alu_ack_i && (state == S_ALU_WAIT) && !rst;

  assign cmd_bad    = (cmd_i.num_words == '0) || (cmd_i.op > 3'(ALU_MEAN));
  assign is_mean    = (op_q == 3'(ALU_MEAN));
  assign fetch_last = ((cnt_q + ONE_WORD) == n_q);
  assign alu_last   = (cnt_q == n_q);

  assign sum_nxt = (state == S_LOAD)
                 ? {{(SUM_WIDTH-INT_WIDTH){1'b0}}, data_i.data}
                 : sum_q + {{(SUM_WIDTH-INT_WIDTH){1'b0}}, data_i.data};

  // Restoring divider step. The partial remainder stays below n, so the
  // borrow out of the trial subtraction alone decides the quotient bit.
  assign rem_sh   = {rem_q, div_q[SUM_WIDTH-1]};
  assign rem_diff = rem_sh - {1'b0, n_q};
  assign rem_ge   = ~rem_diff[NUM_WORD_WIDTH];
  assign rem_step = rem_ge ? rem_diff[NUM_WORD_WIDTH-1:0] : rem_sh[NUM_WORD_WIDTH-1:0];
  assign q_step   = {div_q[SUM_WIDTH-2:0], rem_ge};

  always_ff @(posedge clk) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt  = state;
    cmd_rdy_o  = 1'b0;
    data_rdy_o = 1'b0;
    alu_req_o  = 1'b0;
    alu_op_o   = ALU_OP_E'(op_q);
    alu_a_o    = acc_q;
    alu_b_o    = b_q;
    res_o      = '0;
    err_o      = 1'b0;
    busy_o     = 1'b1;
    case (state)
      S_IDLE: begin
        busy_o    = 1'b0;
        cmd_rdy_o = 1'b1;
        if (cmd_fire) state_nxt = cmd_bad ? S_DONE : S_LOAD;
      end
      S_LOAD: begin
        data_rdy_o = 1'b1;
        if (data_fire) begin
          if (n_q == ONE_WORD) state_nxt = is_mean ? S_MDIV : S_DONE;
          else                 state_nxt = S_FETCH;
        end
      end
      S_FETCH: begin
        data_rdy_o = 1'b1;
        if (data_fire) begin
          if (!is_mean)        state_nxt = S_ALU_WAIT;
          else if (fetch_last) state_nxt = S_MDIV;
        end
      end
      S_ALU_WAIT: begin
        alu_req_o = 1'b1;
        if (ack_fire) state_nxt = alu_last ? S_DONE : S_FETCH;
      end
      S_MDIV: begin
        if (it_q == DIV_LAST) state_nxt = S_DONE;
      end
      S_DONE: begin
        res_o.vld  = 1'b1;
        res_o.data = acc_q;
        err_o      = err_q;
        state_nxt  = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
    // Reset overrides the registered state so outputs drop in the reset cycle itself
    if (rst) begin
      cmd_rdy_o  = 1'b0;
      data_rdy_o = 1'b0;
      alu_req_o  = 1'b0;
      alu_op_o   = ALU_ADD;
      alu_a_o    = '0;
      alu_b_o    = '0;
      res_o      = '0;
      err_o      = 1'b0;
      busy_o     = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_q  <= '0;
      n_q   <= '0;
      cnt_q <= '0;
      acc_q <= '0;
      b_q   <= '0;
      err_q <= 1'b0;
      sum_q <= '0;
      div_q <= '0;
      rem_q <= '0;
      it_q  <= '0;
    end else begin
      case (state)
        S_IDLE: begin
          if (cmd_fire) begin
            op_q  <= cmd_i.op;
            n_q   <= cmd_i.num_words;
            cnt_q <= '0;
            acc_q <= '0;
            err_q <= cmd_bad;
          end
        end
        S_LOAD: begin
          if (data_fire) begin
            acc_q <= data_i.data;
            cnt_q <= ONE_WORD;
            sum_q <= sum_nxt;
            div_q <= sum_nxt;
            rem_q <= '0;
            it_q  <= '0;
          end
        end
        S_FETCH: begin
          if (data_fire) begin
            cnt_q <= cnt_q + ONE_WORD;
            b_q   <= data_i.data;
            sum_q <= sum_nxt;
            div_q <= sum_nxt;
            rem_q <= '0;
            it_q  <= '0;
          end
        end
        S_ALU_WAIT: begin
          if (ack_fire) acc_q <= alu_res_i;
        end
        S_MDIV: begin
          rem_q <= rem_step;
          div_q <= q_step;
          it_q  <= it_q + 5'd1;
          // quotient of an 8-bit mean never exceeds 255, so the low byte is exact
          if (it_q == DIV_LAST) acc_q <= q_step[INT_WIDTH-1:0];
        end
        default: ;
      endcase
    end
  end

  assign state_o = state;

endmodule
